write_post_queue: RTL
=====================

# write_post_queue

Parametrised posted-write buffer between the 6502 core's store path and the shared BRAM/memory port. Captures each core write on the rising edge of its write strobe and drains entries in order whenever the memory side grants a slot. Supersedes the fixed 8/16/32 store queue:
- accepts a push and a pop in the same cycle, including when full;
- forwards the youngest queued data to core reads of the same address;
- flags dropped writes.

## Interface
- DATA_W, 8, data width per entry
- ADDR_W, 16, address width per entry
- DEPTH, 32, number of entries; power of 2, ≥ 2
- FORWARD, 1, 1 = enable read-after-write forwarding; 0 = rd_hit tied 0
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  core write strobe, level; one push per rising edge
- wr_addr  in  ADDR_W  core write address
- wr_data  in  DATA_W  core write data
- rd_addr  in  ADDR_W  core read address, for forwarding lookup
- rd_hit  out  1  a queued entry matches rd_addr
- rd_data  out  DATA_W  data of the youngest matching entry; 0 when rd_hit = 0
- mem_ready  in  1  memory port free this cycle
- mem_we  out  1  head entry is written to memory this cycle
- mem_addr  out  ADDR_W  head entry address
- mem_data  out  DATA_W  head entry data
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky flag: a write edge was dropped
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Edge detect: wr_q <= wr_en each cycle. push_req = wr_en & ~wr_q. Reset value of wr_q is 0, so wr_en held high through reset counts as an edge on the first cycle after reset.
- pop = mem_ready & ~empty. mem_we = pop, combinational.
- mem_addr and mem_data come from the head entry, combinational. Their value is don't-care when empty; the bench checks them only when mem_we = 1.
- push = push_req & (~full | pop). A full queue that is popping in the same cycle accepts the write.
- Dropped write (push_req & full & ~pop):
  - contents are unchanged;
  - overflow <= 1.
- overflow priority: rst > clr_ovf > set. If clr_ovf and a drop happen in the same cycle, overflow is cleared.
- Storage:
  - circular array with write pointer wp and read pointer rp, each $clog2(DEPTH) bits;
  - pointers wrap modulo DEPTH with no special case;
  - count tracks occupancy separately.
- count update:
  - push only: +1;
  - pop only: −1;
  - push and pop together: unchanged, both pointers advance.
- No bypass. A push into an empty queue is not visible at mem_we until the next cycle.
- Forwarding (FORWARD = 1):
  - combinational search over occupied entries, from rp up to rp+count−1;
  - rd_hit = 1 if any entry address equals rd_addr;
  - rd_data = data of the youngest match, nearest wp;
  - the head entry being popped this cycle still participates;
  - a write being pushed this cycle does not participate; it is visible from the next cycle.
- Reset: wp = rp = 0, count = 0, overflow = 0, wr_q = 0. Stored data is not cleared.

## Timing
- Reset values: mem_we = 0, rd_hit = 0, rd_data = 0, count = 0, full = 0, empty = 1, overflow = 0.
- Push latency: a write edge sampled at edge N is in the array after N. It can produce mem_we in the cycle after N at the earliest, if mem_ready = 1.
- Drain throughput: one entry per cycle while mem_ready = 1.
- count, full, empty and overflow are registered and update on the edge after the event.
- rd_hit and rd_data are combinational from current state and rd_addr. There is no registered read path; the consumer registers them alongside BRAM read data.
- rst asserted mid-drain: mem_we goes to 0 in the cycle after the reset edge, and all queued writes are discarded.
- Back-to-back wr_en pulses (1,0,1,0…) produce one push per high cycle. A continuous high level produces one push only.

## Test plan
- Reset, then pulse wr_en with (0x0123, 0xAA), mem_ready = 0 → count = 1, empty = 0. Raise mem_ready → mem_we = 1 for one cycle with mem_addr = 0x0123, mem_data = 0xAA; count = 0 on the following cycle.
- Hold wr_en high for 5 cycles → exactly one push, count = 1.
- mem_ready = 0, 32 write edges with data 0..31 → full = 1. 33rd edge → dropped, overflow = 1. Drain → data 0..31 in order. clr_ovf → overflow = 0.
- Full queue, write edge with mem_ready = 1 in the same cycle → accepted, count stays 32, overflow stays 0. The new data appears last in the drain order.
- FORWARD = 1: queue (0x2010, 0x11) then (0x2010, 0x22), rd_addr = 0x2010 → rd_hit = 1, rd_data = 0x22. rd_addr = 0x2011 → rd_hit = 0, rd_data = 0. After both entries drain → rd_hit = 0.
- Wrap-around: DEPTH = 4. Interleave 10 pushes and pops with mem_ready toggling → output order matches input order and count never exceeds 4. Assert rst mid-stream → count = 0 and mem_we = 0 on the next cycle.

Source files
------------

// File: rtl/write_post_queue.sv
// write_post_queue: posted-write FIFO between core stores and the memory port, with read-after-write forwarding
module write_post_queue #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 32,
  parameter int FORWARD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q, count_d;
  logic wr_q, full_q, empty_q, overflow_q, overflow_d;
  logic push_req, pop, push, drop;
  assign push_req   = wr_en & ~wr_q;
  assign pop        = mem_ready & ~empty_q;
  assign push       = push_req & (~full_q | pop);
  assign drop       = push_req & full_q & ~pop;
  assign count_d    = count_q + CW'(push) - CW'(pop);
  assign overflow_d = clr_ovf ? 1'b0 : (drop | overflow_q);
  assign mem_we     = pop;
  assign mem_addr   = addr_q[rp_q];
  assign mem_data   = data_q[rp_q];
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_en;
      wp_q       <= wp_q + PW'(push);
      rp_q       <= rp_q + PW'(pop);
      count_q    <= count_d;
      full_q     <= count_d == CW'(DEPTH);
      empty_q    <= count_d == '0;
      overflow_q <= overflow_d;
    end
  end
  // storage is intentionally not reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp_q] <= wr_addr;
      data_q[wp_q] <= wr_data;
    end
  end
  // scan oldest to youngest so the last match wins
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (FORWARD != 0 && CW'(i) < count_q && addr_q[rp_q + PW'(i)] == rd_addr) begin
        rd_hit  = 1'b1;
        rd_data = data_q[rp_q + PW'(i)];
      end
    end
  end
endmodule
